wdf_sample_scheduler: RTL and testbench

Sequences a wave-digital-filter datapath core at a fixed sample rate derived from the system clock. Once started, it issues one sample every `SAMPLE_PERIOD` clocks, up to a programmable total: it reads a stimulus word, starts the core, waits for completion and strobes output capture. It sits between the stimulus/pattern source and the WDF core. It also reports sample-rate overruns and hung-core timeouts.

---
 rtl/wdf_sample_scheduler.sv | 145 ++++++++++++++
 tb/tb_wdf_sample_scheduler.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/wdf_sample_scheduler.sv
// rtl/wdf_sample_scheduler.sv - fixed-rate sample sequencer for a WDF datapath core
// Issues one sample per SAMPLE_PERIOD clocks, watches for overruns and hung-core timeouts.
module wdf_sample_scheduler #(
   parameter int SAMPLE_PERIOD  = 8,
   parameter int CNT_W          = 22,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [CNT_W-1:0] total_samples,
   input  logic             core_done,
   output logic             src_rd_en,
   output logic             core_start,
   output logic             out_capture,
   output logic [CNT_W-1:0] sample_index,
   output logic             busy,
   output logic             done,
   output logic             overrun,
   output logic             timeout_err
);

   localparam int TW = (SAMPLE_PERIOD > 2) ? $clog2(SAMPLE_PERIOD) : 1;
   localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_PERIOD - 1);
   localparam logic [WW-1:0] WD_LAST   = WW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_TICK,
      S_ISSUE,
      S_BUSY,
      S_DONE
   } state_e;

   state_e           state_q, state_d;
   logic [TW-1:0]    tick_cnt_q, tick_cnt_d;
   logic [WW-1:0]    wd_q, wd_d;
   logic [CNT_W-1:0] total_q, total_d;
   logic [CNT_W-1:0] index_q, index_d;
   logic             cap_q, cap_d;
   logic             ovr_q, ovr_d;
   logic             to_q, to_d;
   logic             pend_q, pend_d;
   logic             tick;
   logic [CNT_W-1:0] next_index;

   // The tick counter free-runs and is only re-zeroed on start, so sample spacing never drifts.
   assign tick       = (tick_cnt_q == TICK_LAST);
   assign next_index = index_q + CNT_W'(1);

   always_comb begin
      state_d    = state_q;
      tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
      wd_d       = wd_q;
      total_d    = total_q;
      index_d    = index_q;
      cap_d      = 1'b0;
      ovr_d      = ovr_q;
      to_d       = to_q;
      pend_d     = pend_q;
      if (abort) begin
         state_d = S_IDLE;
         pend_d  = 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  total_d    = total_samples;
                  index_d    = '0;
                  tick_cnt_d = '0;
                  ovr_d      = 1'b0;
                  to_d       = 1'b0;
                  pend_d     = 1'b0;
                  state_d    = (total_samples == '0) ? S_DONE : S_WAIT_TICK;
               end
            end
            S_WAIT_TICK: begin
               if (tick) state_d = S_ISSUE;
            end
            S_ISSUE: begin
               wd_d    = '0;
               state_d = S_BUSY;
            end
            S_BUSY: begin
               wd_d = wd_q + WW'(1);
               if (core_done) begin
                  index_d = next_index;
                  cap_d   = 1'b1;
                  pend_d  = 1'b0;
                  if (next_index == total_q)  state_d = S_DONE;
                  else if (pend_q || tick)    state_d = S_ISSUE;
                  else                        state_d = S_WAIT_TICK;
               end else begin
                  // A tick that lands while the core is still working is remembered once.
                  if (tick) begin
                     ovr_d  = 1'b1;
                     pend_d = 1'b1;
                  end
                  if (wd_q == WD_LAST) begin
                     to_d    = 1'b1;
                     state_d = S_DONE;
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         tick_cnt_q <= '0;
         wd_q       <= '0;
         total_q    <= '0;
         index_q    <= '0;
         cap_q      <= 1'b0;
         ovr_q      <= 1'b0;
         to_q       <= 1'b0;
         pend_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         wd_q       <= wd_d;
         total_q    <= total_d;
         index_q    <= index_d;
         cap_q      <= cap_d;
         ovr_q      <= ovr_d;
         to_q       <= to_d;
         pend_q     <= pend_d;
      end
   end

   assign src_rd_en    = (state_q == S_ISSUE);
   assign core_start   = (state_q == S_ISSUE);
   assign out_capture  = cap_q;
   assign sample_index = index_q;
   assign busy         = (state_q == S_WAIT_TICK) || (state_q == S_ISSUE) || (state_q == S_BUSY);
   assign done         = (state_q == S_DONE);
   assign overrun      = ovr_q;
   assign timeout_err  = to_q;

endmodule

// File: tb/tb_wdf_sample_scheduler.sv
// tb/tb_wdf_sample_scheduler.sv - self-checking bench for wdf_sample_scheduler
// Expected behaviour is derived from sample issue/complete times computed arithmetically.
module tb_wdf_sample_scheduler;

   localparam int P    = 8;
   localparam int TO   = 64;
   localparam int CW   = 22;
   localparam int MAXC = 512;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          abort;
   logic [CW-1:0] total_samples;
   logic          core_done;
   logic          src_rd_en;
   logic          core_start;
   logic          out_capture;
   logic [CW-1:0] sample_index;
   logic          busy;
   logic          done;
   logic          overrun;
   logic          timeout_err;

   wdf_sample_scheduler #(
      .SAMPLE_PERIOD (P),
      .CNT_W         (CW),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .abort        (abort),
      .total_samples(total_samples),
      .core_done    (core_done),
      .src_rd_en    (src_rd_en),
      .core_start   (core_start),
      .out_capture  (out_capture),
      .sample_index (sample_index),
      .busy         (busy),
      .done         (done),
      .overrun      (overrun),
      .timeout_err  (timeout_err)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   bit e_start [MAXC];
   bit e_cap   [MAXC];
   bit e_drive [MAXC];
   bit e_busy  [MAXC];
   bit e_done  [MAXC];
   bit e_ovr   [MAXC];
   bit e_to    [MAXC];
   int e_idx   [MAXC];
   int lat_q[$];
   int obs_starts[$];
   int run_len;
   int end_cycle;

   task automatic chk(input string tag, input longint obs, input longint expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " src_rd_en"}, src_rd_en, 0);
      chk({tag, " core_start"}, core_start, 0);
      chk({tag, " out_capture"}, out_capture, 0);
      chk({tag, " sample_index"}, sample_index, 0);
      chk({tag, " busy"}, busy, 0);
      chk({tag, " done"}, done, 0);
      chk({tag, " overrun"}, overrun, 0);
      chk({tag, " timeout_err"}, timeout_err, 0);
   endtask

   // Sample k is issued at t, completes at t+lat; ticks fall on multiples of P.
   function automatic void build_model(input int total);
      int t, d, m, w, ovr_from, to_from, cnt;
      for (int c = 0; c < MAXC; c++) begin
         e_start[c] = 0; e_cap[c] = 0; e_drive[c] = 0;
      end
      t = P + 1; ovr_from = -1; to_from = -1; end_cycle = 1;
      for (int k = 0; k < total; k++) begin
         e_start[t] = 1;
         m = (t / P + 1) * P;
         w = (lat_q[k] <= TO) ? t + lat_q[k] - 1 : t + TO;
         if (m <= w && ovr_from < 0) ovr_from = m + 1;
         if (lat_q[k] > TO) begin
            to_from = t + TO + 1;
            end_cycle = to_from;
            break;
         end
         d = t + lat_q[k];
         e_drive[d] = 1;
         e_cap[d + 1] = 1;
         end_cycle = d + 1;
         t = (m <= d) ? d + 1 : (d / P + 1) * P + 1;
      end
      cnt = 0;
      for (int c = 0; c < MAXC; c++) begin
         if (e_cap[c]) cnt++;
         e_idx[c]  = cnt;
         e_busy[c] = (c >= 1) && (c < end_cycle);
         e_done[c] = (c >= end_cycle);
         e_ovr[c]  = (ovr_from >= 0) && (c >= ovr_from);
         e_to[c]   = (to_from >= 0) && (c >= to_from);
      end
      run_len = end_cycle + 4;
   endfunction

   task automatic run_model(input string name, input int total, input bit noisy);
      int spur;
      build_model(total);
      obs_starts.delete();
      spur = (total > 0) ? $urandom_range(end_cycle - 1, 1) : -1;
      for (int c = 0; c < run_len; c++) begin
         @(negedge clk);
         abort         = 1'b0;
         start         = (c == 0) || (noisy && c == spur);
         total_samples = (c == 0 || !noisy) ? CW'(total) : CW'($urandom_range(9, 0));
         core_done     = e_drive[c];
         #1;
         if (core_start) obs_starts.push_back(c);
         if (c >= 1) begin
            chk($sformatf("%s c%0d core_start", name, c), core_start, e_start[c]);
            chk($sformatf("%s c%0d src_rd_en", name, c), src_rd_en, e_start[c]);
            chk($sformatf("%s c%0d out_capture", name, c), out_capture, e_cap[c]);
            chk($sformatf("%s c%0d sample_index", name, c), sample_index, e_idx[c]);
            chk($sformatf("%s c%0d busy", name, c), busy, e_busy[c]);
            chk($sformatf("%s c%0d done", name, c), done, e_done[c]);
            chk($sformatf("%s c%0d overrun", name, c), overrun, e_ovr[c]);
            chk($sformatf("%s c%0d timeout_err", name, c), timeout_err, e_to[c]);
         end
      end
      start = 1'b0;
      core_done = 1'b0;
   endtask

   task automatic chk_starts(input string name, input int exp_list[$]);
      chk({name, " start_count"}, obs_starts.size(), exp_list.size());
      for (int i = 0; i < exp_list.size(); i++)
         chk($sformatf("%s start%0d_cycle", name, i),
             (obs_starts.size() > i) ? obs_starts[i] : -1, exp_list[i]);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; abort = 1'b0; core_done = 1'b0; total_samples = '0;
      repeat (2) @(negedge clk);
      #1;
      chk_zero("reset");
      @(negedge clk);
      reset = 1'b0;

      lat_q = '{3, 3, 3};
      run_model("nominal", 3, 0);
      chk_starts("nominal", '{9, 17, 25});

      run_model("empty", 0, 0);
      chk("empty start_count", obs_starts.size(), 0);

      lat_q = '{10, 10};
      run_model("overrun", 2, 0);
      chk_starts("overrun", '{9, 20});

      lat_q = '{1000};
      run_model("timeout", 5, 0);
      chk_starts("timeout", '{9});

      lat_q = '{TO};
      run_model("wd_edge", 1, 0);
      chk("wd_edge final_index", sample_index, 1);

      for (int c = 0; c <= 40; c++) begin
         @(negedge clk);
         start = (c == 0); abort = (c == 12); core_done = (c == 14); total_samples = 3;
         #1;
         if (c == 9) chk("abort c9 core_start", core_start, 1);
         if (c >= 13) begin
            chk($sformatf("abort c%0d busy", c), busy, 0);
            chk($sformatf("abort c%0d core_start", c), core_start, 0);
            chk($sformatf("abort c%0d done", c), done, 0);
         end
      end
      for (int c = 0; c <= 20; c++) begin
         @(negedge clk);
         start = (c == 0); abort = (c == 0); core_done = 1'b0; total_samples = 2;
         #1;
         if (c >= 1) begin
            chk($sformatf("start_abort c%0d busy", c), busy, 0);
            chk($sformatf("start_abort c%0d done", c), done, 0);
            chk($sformatf("start_abort c%0d core_start", c), core_start, 0);
         end
      end
      abort = 1'b0;

      for (int c = 0; c <= 9; c++) begin
         @(negedge clk);
         start = (c == 0); total_samples = 3;
         #1;
      end
      chk("areset pre core_start", core_start, 1);
      #2 reset = 1'b1;
      #1;
      chk_zero("areset");
      @(negedge clk);
      reset = 1'b0;
      lat_q = '{3, 3};
      run_model("post_reset", 2, 0);
      chk_starts("post_reset", '{9, 17});

      for (int r = 0; r < 6; r++) begin
         int tot;
         tot = $urandom_range(6, 1);
         lat_q.delete();
         for (int k = 0; k < tot; k++) lat_q.push_back($urandom_range(2 * P + 2, 1));
         run_model($sformatf("rand%0d", r), tot, 1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
